// File: rtl/cflog_slice_mem.sv
// CFLog store split into a ring of slices. Hardware fills one slice while the
// controller drains closed slices; drops are counted while the ring is full.
module cflog_slice_mem #(
  parameter int ADDR_MSB   = 6,
  parameter int MEM_SIZE   = 256,
  parameter int NUM_SLICES = 2
) (
  input  logic                ram_clk,
  input  logic                puc_rst,
  input  logic                cflow_hw_wen,
  input  logic [15:0]         cflow_src,
  input  logic [15:0]         cflow_dest,
  input  logic                log_flush,
  input  logic                slice_release,
  input  logic                ovf_clr,
  input  logic [ADDR_MSB:0]   ram_addr,
  input  logic                ram_cen,
  output logic [15:0]         ram_dout,
  input  logic [ADDR_MSB:0]   read_addr_hw,
  output logic [15:0]         read_val_log,
  output logic [ADDR_MSB:0]   cflow_logs_ptr,
  output logic                rpt_valid,
  output logic [ADDR_MSB:0]   rpt_base,
  output logic [ADDR_MSB+1:0] rpt_len,
  output logic                log_overflow,
  output logic [15:0]         drop_cnt
);
  localparam int AW    = ADDR_MSB + 1;
  localparam int DEPTH = MEM_SIZE / 2;
  localparam int SW    = DEPTH / NUM_SLICES;
  localparam int IW    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);
  localparam logic [AW:0]   SW_L     = (AW+1)'(SW);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_FREE, S_FILLING, S_CLOSED} slice_st_t;
  typedef enum logic {W_LOG, W_STALL} wr_st_t;

  function automatic logic [AW-1:0] base_of(input logic [IW-1:0] idx);
    return AW'(int'(idx) * SW);
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  logic [15:0]   r_mem [DEPTH];
  wr_st_t        r_wstate, w_wstate_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic [IW-1:0] r_fill_idx, w_fill_nxt;
  logic [IW-1:0] r_rpt_idx, w_rpt_idx_nxt;
  slice_st_t     r_slice_st [NUM_SLICES];
  slice_st_t     w_st_nxt   [NUM_SLICES];
  logic [AW:0]   r_slice_len [NUM_SLICES];
  logic [AW:0]   w_len_nxt   [NUM_SLICES];
  logic          r_rpt_valid;
  logic [AW-1:0] r_rpt_base;
  logic [AW:0]   r_rpt_len;
  logic          r_ovf;
  logic [15:0]   r_drop_cnt;
  logic [AW-1:0] r_sw_addr;

  logic [AW-1:0] w_base;
  logic [IW-1:0] w_nxt_idx;
  logic          w_wr, w_close, w_drop, w_rel;
  logic [AW:0]   w_used;

  always_comb begin
    w_base    = base_of(r_fill_idx);
    w_nxt_idx = next_idx(r_fill_idx);
    w_wr      = (r_wstate == W_LOG) && cflow_hw_wen;
    // words in the filling slice once this cycle's pair is committed
    w_used    = {1'b0, r_ptr - w_base} + (w_wr ? (AW+1)'(2) : '0);
    w_close   = (r_wstate == W_LOG) &&
                ((w_used == SW_L) || (log_flush && (w_used != '0)));
    w_drop    = (r_wstate == W_STALL) && cflow_hw_wen;
    w_rel     = slice_release && r_rpt_valid;
  end

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_ptr_nxt     = r_ptr;
    w_fill_nxt    = r_fill_idx;
    w_rpt_idx_nxt = r_rpt_idx;
    w_st_nxt      = r_slice_st;
    w_len_nxt     = r_slice_len;
    if (w_rel) begin
      w_st_nxt[r_rpt_idx] = S_FREE;
      w_rpt_idx_nxt       = next_idx(r_rpt_idx);
    end
    case (r_wstate)
      W_LOG: begin
        if (w_close) begin
          w_st_nxt[r_fill_idx]  = S_CLOSED;
          w_len_nxt[r_fill_idx] = w_used;
          w_fill_nxt            = w_nxt_idx;
          w_ptr_nxt             = base_of(w_nxt_idx);
          // pre-release state decides: a slice freed this edge is not yet reusable
          if (r_slice_st[w_nxt_idx] == S_FREE) w_st_nxt[w_nxt_idx] = S_FILLING;
          else                                 w_wstate_nxt        = W_STALL;
        end else if (w_wr) begin
          w_ptr_nxt = r_ptr + AW'(2);
        end
      end
      W_STALL: begin
        if (r_slice_st[r_fill_idx] == S_FREE) begin
          w_st_nxt[r_fill_idx] = S_FILLING;
          w_wstate_nxt         = W_LOG;
        end
      end
      default: w_wstate_nxt = W_LOG;
    endcase
  end

  always_ff @(posedge ram_clk or posedge puc_rst) begin
    if (puc_rst) begin
      r_wstate    <= W_LOG;
      r_ptr       <= '0;
      r_fill_idx  <= '0;
      r_rpt_idx   <= '0;
      for (int i = 0; i < NUM_SLICES; i++) begin
        r_slice_st[i]  <= (i == 0) ? S_FILLING : S_FREE;
        r_slice_len[i] <= '0;
      end
      r_rpt_valid <= 1'b0;
      r_rpt_base  <= '0;
      r_rpt_len   <= '0;
    end else begin
      r_wstate    <= w_wstate_nxt;
      r_ptr       <= w_ptr_nxt;
      r_fill_idx  <= w_fill_nxt;
      r_rpt_idx   <= w_rpt_idx_nxt;
      r_slice_st  <= w_st_nxt;
      r_slice_len <= w_len_nxt;
      r_rpt_valid <= (w_st_nxt[w_rpt_idx_nxt] == S_CLOSED);
      r_rpt_base  <= base_of(w_rpt_idx_nxt);
      r_rpt_len   <= (w_st_nxt[w_rpt_idx_nxt] == S_CLOSED) ? w_len_nxt[w_rpt_idx_nxt] : '0;
    end
  end

  always_ff @(posedge ram_clk or posedge puc_rst) begin
    if (puc_rst) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
      r_sw_addr  <= '0;
    end else begin
      if (w_drop) begin
        r_ovf      <= 1'b1;
        r_drop_cnt <= ovf_clr ? 16'd1 :
                      (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : r_drop_cnt + 16'd1;
      end else if (ovf_clr) begin
        r_ovf      <= 1'b0;
        r_drop_cnt <= '0;
      end
      if (!ram_cen && ({1'b0, ram_addr} < DEPTH_L)) r_sw_addr <= ram_addr;
    end
  end

  always_ff @(posedge ram_clk) begin
    if (w_wr) begin
      r_mem[r_ptr]          <= cflow_src;
      r_mem[r_ptr + AW'(1)] <= cflow_dest;
    end
  end

  assign ram_dout       = r_mem[r_sw_addr];
  assign read_val_log   = r_mem[read_addr_hw];
  assign cflow_logs_ptr = r_ptr;
  assign rpt_valid      = r_rpt_valid;
  assign rpt_base       = r_rpt_base;
  assign rpt_len        = r_rpt_len;
  assign log_overflow   = r_ovf;
  assign drop_cnt       = r_drop_cnt;
endmodule

// File: tb/tb_cflog_slice_mem.sv
// Bench for cflog_slice_mem: vector table, directed corner sequences and a
// randomized run against a slice-ring reference model.
module tb_cflog_slice_mem;
  localparam int N     = 2;
  localparam int DEPTH = 128;
  localparam int SW    = DEPTH / N;

  logic        ram_clk = 1'b0;
  logic        puc_rst = 1'b0;
  logic        cflow_hw_wen = 1'b0;
  logic [15:0] cflow_src = '0, cflow_dest = '0;
  logic        log_flush = 1'b0, slice_release = 1'b0, ovf_clr = 1'b0;
  logic [6:0]  ram_addr = '0;
  logic        ram_cen = 1'b1;
  logic [15:0] ram_dout;
  logic [6:0]  read_addr_hw = '0;
  logic [15:0] read_val_log;
  logic [6:0]  cflow_logs_ptr;
  logic        rpt_valid;
  logic [6:0]  rpt_base;
  logic [7:0]  rpt_len;
  logic        log_overflow;
  logic [15:0] drop_cnt;

  cflog_slice_mem dut (
    .ram_clk(ram_clk), .puc_rst(puc_rst), .cflow_hw_wen(cflow_hw_wen),
    .cflow_src(cflow_src), .cflow_dest(cflow_dest), .log_flush(log_flush),
    .slice_release(slice_release), .ovf_clr(ovf_clr), .ram_addr(ram_addr),
    .ram_cen(ram_cen), .ram_dout(ram_dout), .read_addr_hw(read_addr_hw),
    .read_val_log(read_val_log), .cflow_logs_ptr(cflow_logs_ptr),
    .rpt_valid(rpt_valid), .rpt_base(rpt_base), .rpt_len(rpt_len),
    .log_overflow(log_overflow), .drop_cnt(drop_cnt)
  );

  always #5 ram_clk = ~ram_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // reference model: ring of slices with a FIFO of closed slices
  int mem_m [DEPTH];
  bit is_free [N];
  int closed_q [$];
  int len_of [N];
  int fill_slice, fill_cnt, rel_count, dcnt, sw_addr_m;
  bit stalled, ovf_m, use_model;

  task automatic model_reset();
    fill_slice = 0; fill_cnt = 0; stalled = 0; rel_count = 0;
    closed_q.delete();
    for (int i = 0; i < N; i++) begin is_free[i] = (i != 0); len_of[i] = 0; end
    ovf_m = 0; dcnt = 0; sw_addr_m = 0;
  endtask

  task automatic model_step(input bit wen, input int s, input int d,
                            input bit fl, input bit rl, input bit cl);
    bit pre_free [N];
    bit rel_ok, drop;
    int nxt;
    pre_free = is_free;
    rel_ok = (closed_q.size() > 0);
    drop = stalled && wen;
    if (!stalled) begin
      if (wen) begin
        mem_m[fill_slice*SW + fill_cnt]     = s;
        mem_m[fill_slice*SW + fill_cnt + 1] = d;
        fill_cnt += 2;
      end
      if (fill_cnt == SW || (fl && fill_cnt > 0)) begin
        closed_q.push_back(fill_slice);
        len_of[fill_slice] = fill_cnt;
        nxt = (fill_slice + 1) % N;
        fill_slice = nxt;
        fill_cnt = 0;
        if (pre_free[nxt]) is_free[nxt] = 0;
        else stalled = 1;
      end
    end else if (pre_free[fill_slice]) begin
      stalled = 0;
      is_free[fill_slice] = 0;
    end
    if (rl && rel_ok) begin
      is_free[closed_q.pop_front()] = 1;
      rel_count++;
    end
    if (drop) begin
      ovf_m = 1;
      dcnt = cl ? 1 : ((dcnt < 65535) ? dcnt + 1 : dcnt);
    end else if (cl) begin
      ovf_m = 0; dcnt = 0;
    end
    if (!ram_cen && ram_addr < DEPTH) sw_addr_m = ram_addr;
  endtask

  task automatic model_check();
    bit v;
    v = (closed_q.size() > 0);
    chk("m_ptr", cflow_logs_ptr, fill_slice*SW + fill_cnt);
    chk("m_rpt_valid", rpt_valid, v);
    chk("m_rpt_base", rpt_base, (rel_count % N) * SW);
    chk("m_rpt_len", rpt_len, v ? len_of[closed_q[0]] : 0);
    chk("m_overflow", log_overflow, ovf_m);
    chk("m_drop_cnt", drop_cnt, dcnt);
    if (mem_m[read_addr_hw] >= 0) chk("m_read_val_log", read_val_log, mem_m[read_addr_hw]);
    if (mem_m[sw_addr_m] >= 0)    chk("m_ram_dout", ram_dout, mem_m[sw_addr_m]);
  endtask

  task automatic cyc(input bit wen, input logic [15:0] s, input logic [15:0] d,
                     input bit fl, input bit rl, input bit cl);
    cflow_hw_wen = wen; cflow_src = s; cflow_dest = d;
    log_flush = fl; slice_release = rl; ovf_clr = cl;
    @(posedge ram_clk);
    model_step(wen, int'(s), int'(d), fl, rl, cl);
    #1;
    if (use_model) model_check();
    cflow_hw_wen = 0; log_flush = 0; slice_release = 0; ovf_clr = 0;
  endtask

  task automatic do_reset();
    puc_rst = 1;
    #3;
    model_reset();
    puc_rst = 0;
  endtask

  task automatic chk_state(input string tag, input int p, input int v, input int b,
                           input int l, input int o, input int dc);
    chk({tag, "_ptr"}, cflow_logs_ptr, p);
    chk({tag, "_rpt_valid"}, rpt_valid, v);
    chk({tag, "_rpt_base"}, rpt_base, b);
    chk({tag, "_rpt_len"}, rpt_len, l);
    chk({tag, "_overflow"}, log_overflow, o);
    chk({tag, "_drop_cnt"}, drop_cnt, dc);
  endtask

  typedef struct {
    bit wen; bit fl; bit rl; bit cl;
    int ptr; bit v; int base; int len; bit ovf; int dc;
  } vec_t;
  vec_t tbl [19];

  initial begin
    tbl[0]  = '{1,0,0,0,  2,1'b0, 0, 0,1'b0,0};
    tbl[1]  = '{1,0,0,0,  4,1'b0, 0, 0,1'b0,0};
    tbl[2]  = '{1,0,0,0,  6,1'b0, 0, 0,1'b0,0};
    tbl[3]  = '{1,0,0,0,  8,1'b0, 0, 0,1'b0,0};
    tbl[4]  = '{1,0,0,0, 10,1'b0, 0, 0,1'b0,0};
    tbl[5]  = '{0,1,0,0, 64,1'b1, 0,10,1'b0,0};
    tbl[6]  = '{0,1,0,0, 64,1'b1, 0,10,1'b0,0};
    tbl[7]  = '{1,0,0,0, 66,1'b1, 0,10,1'b0,0};
    tbl[8]  = '{1,0,0,0, 68,1'b1, 0,10,1'b0,0};
    tbl[9]  = '{1,0,0,0, 70,1'b1, 0,10,1'b0,0};
    tbl[10] = '{1,1,0,0,  0,1'b1, 0,10,1'b0,0};
    tbl[11] = '{1,0,0,0,  0,1'b1, 0,10,1'b1,1};
    tbl[12] = '{1,0,0,0,  0,1'b1, 0,10,1'b1,2};
    tbl[13] = '{1,0,1,1,  0,1'b1,64, 8,1'b1,1};
    tbl[14] = '{0,0,0,0,  0,1'b1,64, 8,1'b1,1};
    tbl[15] = '{0,0,0,1,  0,1'b1,64, 8,1'b0,0};
    tbl[16] = '{1,0,0,0,  2,1'b1,64, 8,1'b0,0};
    tbl[17] = '{0,0,1,0,  2,1'b0, 0, 0,1'b0,0};
    tbl[18] = '{0,1,0,0, 64,1'b1, 0, 2,1'b0,0};

    for (int i = 0; i < DEPTH; i++) mem_m[i] = -1;
    use_model = 0;

    // reset state, single write, both read ports
    do_reset();
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    ram_addr = 0; ram_cen = 0;
    cyc(1, 16'hE000, 16'hE010, 0, 0, 0);
    ram_cen = 1;
    chk("t1_ptr", cflow_logs_ptr, 2);
    read_addr_hw = 1; #1;
    chk("t1_hw_read1", read_val_log, 16'hE010);
    read_addr_hw = 0; #1;
    chk("t1_hw_read0", read_val_log, 16'hE000);
    chk("t1_sw_read", ram_dout, 16'hE000);

    // vector table: flush, empty flush, write+flush, stall drops, clr vs drop
    do_reset();
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].wen, 16'h5000 + 16'(i), 16'h6000 + 16'(i), tbl[i].fl, tbl[i].rl, tbl[i].cl);
      chk_state($sformatf("tbl%0d", i), tbl[i].ptr, tbl[i].v, tbl[i].base,
                tbl[i].len, tbl[i].ovf, tbl[i].dc);
    end

    // full slice close, overflow while both slices closed, release recovery
    do_reset();
    for (int k = 0; k < 32; k++) cyc(1, 16'h1000 + 16'(k), 16'h2000 + 16'(k), 0, 0, 0);
    chk_state("t2_full", 64, 1, 0, 64, 0, 0);
    cyc(1, 16'hA033, 16'hB033, 0, 0, 0);
    read_addr_hw = 64; #1;
    chk("t2_w64", read_val_log, 16'hA033);
    read_addr_hw = 65; #1;
    chk("t2_w65", read_val_log, 16'hB033);
    for (int k = 0; k < 31; k++) cyc(1, 16'h3000 + 16'(k), 16'h4000 + 16'(k), 0, 0, 0);
    chk_state("t3_stall", 0, 1, 0, 64, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 16'hDEAD, 16'hBEEF, 0, 0, 0);
    chk_state("t3_drops", 0, 1, 0, 64, 1, 3);
    cyc(0, 0, 0, 0, 1, 0);
    chk_state("t3_release", 0, 1, 64, 64, 1, 3);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 16'hC000, 16'hC001, 0, 0, 0);
    read_addr_hw = 0; #1;
    chk("t3_resume_w0", read_val_log, 16'hC000);
    chk("t3_resume_ptr", cflow_logs_ptr, 2);

    // asynchronous reset in the middle of a cycle
    do_reset();
    for (int k = 0; k < 35; k++) cyc(1, 16'h7000 + 16'(k), 16'h7100 + 16'(k), 0, 0, 0);
    chk("t6_pre_ptr", cflow_logs_ptr, 70);
    chk("t6_pre_valid", rpt_valid, 1);
    puc_rst = 1; #1;
    chk("t6_async_valid", rpt_valid, 0);
    chk("t6_async_ptr", cflow_logs_ptr, 0);
    #2;
    model_reset();
    puc_rst = 0;
    cyc(1, 16'hD000, 16'hD001, 0, 0, 0);
    read_addr_hw = 0; #1;
    chk("t6_restart_w0", read_val_log, 16'hD000);
    chk("t6_restart_ptr", cflow_logs_ptr, 2);

    // randomized run against the reference model
    use_model = 1;
    for (int c = 0; c < 3000; c++) begin
      read_addr_hw = 7'($urandom_range(0, DEPTH - 1));
      ram_addr     = 7'($urandom_range(0, DEPTH - 1));
      ram_cen      = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 9) < 6, 16'($urandom), 16'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
